// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared types and constants for the rv_cpu memory arbiter
//
// Purpose : response-state encoding and the byte-enable / load-store
//           constants shared by the rv_cpu memory path.
// Ports   : none (package).

package rv_mem_pkg;

    // Which requester owns the read data returning from the RAM this cycle.
    typedef enum logic [1:0] {
        S_NONE = 2'd0,
        S_IM   = 2'd1,
        S_DM   = 2'd2
    } resp_state_t;

    // Load/store access sizes, as already used by the rv_cpu core.
    localparam logic [1:0] LDST_B = 2'd0;
    localparam logic [1:0] LDST_H = 2'd1;
    localparam logic [1:0] LDST_W = 2'd2;

    // RAM byte write enables; BE_NONE turns an access into a read.
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_B0      = 4'b0001;
    localparam logic [3:0] BE_B1      = 4'b0010;
    localparam logic [3:0] BE_B2      = 4'b0100;
    localparam logic [3:0] BE_B3      = 4'b1000;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/rv_mem_arbiter_if.sv
// rtl/rv_mem_arbiter_if.sv - CPU fetch/data ports and RAM port seen by the arbiter
//
// Purpose : bundles the rv_cpu instruction-fetch port, data port and the
//           single-port RAM port.
// Modports: slave  - the arbiter (takes CPU requests, drives the RAM).
//           master - the surroundings (CPU requesters plus RAM).
// Signals : im_*  fetch request/grant/response, dm_* data request/grant/
//           response, ram_* word address, write data, byte enables, read data.

interface rv_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 14
);
    logic [31:0]           im_addr_i;
    logic                  im_rd_i;
    logic                  im_gnt_o;
    logic [31:0]           im_data_o;
    logic                  im_valid_o;

    logic [31:0]           dm_addr_i;
    logic [31:0]           dm_data_s_i;
    logic [3:0]            dm_data_select_i;
    logic                  dm_write_i;
    logic                  dm_load_i;
    logic                  dm_gnt_o;
    logic [31:0]           dm_data_l_o;
    logic                  dm_rvalid_o;

    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [31:0]           ram_data_o;
    logic [3:0]            ram_bwe_o;
    logic [31:0]           ram_data_i;

    modport slave (
        input  im_addr_i, im_rd_i,
        output im_gnt_o, im_data_o, im_valid_o,
        input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_write_i, dm_load_i,
        output dm_gnt_o, dm_data_l_o, dm_rvalid_o,
        output ram_addr_o, ram_data_o, ram_bwe_o,
        input  ram_data_i
    );

    modport master (
        output im_addr_i, im_rd_i,
        input  im_gnt_o, im_data_o, im_valid_o,
        output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_write_i, dm_load_i,
        input  dm_gnt_o, dm_data_l_o, dm_rvalid_o,
        input  ram_addr_o, ram_data_o, ram_bwe_o,
        output ram_data_i
    );

endinterface

// File: rtl/rv_mem_prio_sel.sv
// rtl/rv_mem_prio_sel.sv - fixed-priority grant selector with fetch starvation override
//
// Purpose : data requests win over fetch, except when fetch has already been
//           denied MAX_IM_STALL cycles in a row; then fetch wins once.
// Ports   : en_i      grants forced low when 0 (reset)
//           im_rd_i   fetch request
//           dm_req_i  data request (load or store)
//           starve_i  consecutive denied fetch cycles (saturating)
//           im_gnt_o  fetch granted
//           dm_gnt_o  data granted

module rv_mem_prio_sel #(
    parameter int MAX_IM_STALL = 4   // 1..15, fits the 4-bit counter
) (
    input  logic       en_i,
    input  logic       im_rd_i,
    input  logic       dm_req_i,
    input  logic [3:0] starve_i,
    output logic       im_gnt_o,
    output logic       dm_gnt_o
);

    logic im_starving;
    logic dm_wins;

    assign im_starving = im_rd_i & (starve_i == 4'(MAX_IM_STALL));
    assign dm_wins     = dm_req_i & ~im_starving;

    // The two grants are mutually exclusive by construction.
    assign dm_gnt_o = en_i & dm_wins;
    assign im_gnt_o = en_i & im_rd_i & ~dm_wins;

endmodule

// File: rtl/rv_mem_arbiter.sv
// rtl/rv_mem_arbiter.sv - shares one single-port RAM between rv_cpu fetch and data ports
//
// Purpose : grants at most one RAM access per cycle (data first, fetch
//           protected by a starvation counter) and steers the 1-cycle-latency
//           read data back to whichever port issued the read.
// Ports   : clk_i    clock
//           rst_n_i  asynchronous active-low reset
//           bus      rv_mem_arbiter_if.slave (CPU im_*/dm_* ports, RAM ram_* port)

module rv_mem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 14,
    parameter int MAX_IM_STALL = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    rv_mem_arbiter_if.slave bus
);

    logic                  dm_req;
    logic                  im_gnt;
    logic                  dm_gnt;
    logic                  dm_store;
    logic                  dm_load_only;
    logic [3:0]            starve;
    logic [ADDR_WIDTH-1:0] im_word;
    logic [ADDR_WIDTH-1:0] dm_word;
    resp_state_t           state;
    resp_state_t           state_nxt;
    logic [31:0]           im_data_q;
    logic [31:0]           dm_data_q;
    logic                  im_valid;
    logic                  dm_rvalid;
    logic [31:0]           im_data;
    logic [31:0]           dm_data;

    // Byte offset and bits above the RAM size are ignored: addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.im_addr_i, bus.dm_addr_i};

    assign im_word = bus.im_addr_i[ADDR_WIDTH+1:2];
    assign dm_word = bus.dm_addr_i[ADDR_WIDTH+1:2];

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign dm_req = bus.dm_write_i | bus.dm_load_i;

    rv_mem_prio_sel #(
        .MAX_IM_STALL (MAX_IM_STALL)
    ) u_prio_sel (
        .en_i     (rst_n_i),
        .im_rd_i  (bus.im_rd_i),
        .dm_req_i (dm_req),
        .starve_i (starve),
        .im_gnt_o (im_gnt),
        .dm_gnt_o (dm_gnt)
    );

    // A simultaneous store+load is illegal; the store takes the slot and
    // no load response is produced.
    assign dm_store     = dm_gnt & bus.dm_write_i;
    assign dm_load_only = dm_gnt & bus.dm_load_i & ~bus.dm_write_i;

    assign bus.im_gnt_o = im_gnt;
    assign bus.dm_gnt_o = dm_gnt;

    // ------------------------------------------------------------------
    // RAM drive: idle cycles park the address on the fetch port.
    // A store with all byte enables low is a harmless no-op.
    // ------------------------------------------------------------------
    assign bus.ram_addr_o = dm_gnt ? dm_word : im_word;
    assign bus.ram_bwe_o  = dm_store ? bus.dm_data_select_i : BE_NONE;
    assign bus.ram_data_o = bus.dm_data_s_i;

    // ------------------------------------------------------------------
    // Starvation counter: consecutive cycles with fetch pending but denied.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve <= '0;
        end else if (!bus.im_rd_i || im_gnt) begin
            starve <= '0;
        end else if (starve != 4'(MAX_IM_STALL)) begin
            starve <= starve + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Response FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_NONE;
        end else begin
            state <= state_nxt;
        end
    end

    // Response FSM: next state (who owns next cycle's RAM read data)
    always_comb begin
        state_nxt = S_NONE;
        if (im_gnt) begin
            state_nxt = S_IM;
        end else if (dm_load_only) begin
            state_nxt = S_DM;
        end
    end

    // Response FSM: outputs. Read data is forwarded straight from the RAM
    // during the response cycle so valid and data line up; the holding
    // registers keep the last word afterwards.
    always_comb begin
        im_valid  = (state == S_IM);
        dm_rvalid = (state == S_DM);
        im_data   = im_valid  ? bus.ram_data_i : im_data_q;
        dm_data   = dm_rvalid ? bus.ram_data_i : dm_data_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            im_data_q <= '0;
            dm_data_q <= '0;
        end else begin
            if (im_valid) begin
                im_data_q <= bus.ram_data_i;
            end
            if (dm_rvalid) begin
                dm_data_q <= bus.ram_data_i;
            end
        end
    end

    assign bus.im_valid_o  = im_valid;
    assign bus.im_data_o   = im_data;
    assign bus.dm_rvalid_o = dm_rvalid;
    assign bus.dm_data_l_o = dm_data;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb/tb_rv_mem_arbiter.sv - self-checking bench for rv_mem_arbiter

module tb_rv_mem_arbiter;

    localparam int AW        = 14;
    localparam int MAX_STALL = 4;
    localparam int DEPTH     = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv_mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    rv_mem_arbiter #(
        .ADDR_WIDTH   (AW),
        .MAX_IM_STALL (MAX_STALL)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[8*k +: 8] = wdata[8*k +: 8];
        end
        return r;
    endfunction

    // Environment RAM: single port, write-first, one cycle read latency.
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        bus.ram_data_i         <= merge(ram[bus.ram_addr_o], bus.ram_data_o, bus.ram_bwe_o);
        ram[bus.ram_addr_o]    <= merge(ram[bus.ram_addr_o], bus.ram_data_o, bus.ram_bwe_o);
    end

    // Store and load together is an illegal request.
    always @(posedge clk) begin
        if (rst_n) assert (!(bus.dm_write_i && bus.dm_load_i))
            else $error("illegal simultaneous store and load request");
    end

    // Reference model: memory contents, consecutive fetch denials,
    // response expected next cycle, last delivered words.
    logic [31:0] ref_mem [DEPTH];
    int          im_wait;
    int          pend;          // 0 none, 1 fetch, 2 load
    logic [31:0] pend_data;
    logic [31:0] last_im;
    logic [31:0] last_dm;

    task automatic model_reset();
        im_wait = 0;
        pend    = 0;
        last_im = '0;
        last_dm = '0;
    endtask

    // One clock cycle: drive requests, check everything the DUT shows in
    // this cycle, then advance the model across the coming edge.
    task automatic cycle(input logic im_rd, input logic [31:0] im_addr,
                         input logic dm_w, input logic dm_l, input logic [31:0] dm_addr,
                         input logic [31:0] dm_wdata, input logic [3:0] sel,
                         output logic g_im, output logic g_dm);
        int   wi, wd;
        logic starving;
        @(negedge clk);
        bus.im_rd_i          = im_rd;
        bus.im_addr_i        = im_addr;
        bus.dm_write_i       = dm_w;
        bus.dm_load_i        = dm_l;
        bus.dm_addr_i        = dm_addr;
        bus.dm_data_s_i      = dm_wdata;
        bus.dm_data_select_i = sel;
        #1;
        if (pend == 1) last_im = pend_data;
        if (pend == 2) last_dm = pend_data;
        chk("im_valid",  32'(bus.im_valid_o),  32'(pend == 1));
        chk("im_data",   bus.im_data_o,        last_im);
        chk("dm_rvalid", 32'(bus.dm_rvalid_o), 32'(pend == 2));
        chk("dm_data",   bus.dm_data_l_o,      last_dm);

        wi = int'((im_addr / 4) % DEPTH);
        wd = int'((dm_addr / 4) % DEPTH);
        starving = im_rd && (im_wait >= MAX_STALL);
        g_dm = (dm_w || dm_l) && !starving;
        g_im = im_rd && !g_dm;
        chk("im_gnt",   32'(bus.im_gnt_o),  32'(g_im));
        chk("dm_gnt",   32'(bus.dm_gnt_o),  32'(g_dm));
        chk("ram_addr", 32'(bus.ram_addr_o), 32'(g_dm ? wd : wi));
        chk("ram_bwe",  32'(bus.ram_bwe_o),  32'((g_dm && dm_w) ? sel : 4'b0000));
        if (g_dm && dm_w) chk("ram_wdata", bus.ram_data_o, dm_wdata);

        if (im_rd && !g_im) begin
            if (im_wait < MAX_STALL) im_wait++;
        end else begin
            im_wait = 0;
        end
        pend = 0;
        if (g_im) begin
            pend      = 1;
            pend_data = ref_mem[wi];
        end else if (g_dm && dm_w) begin
            ref_mem[wd] = merge(ref_mem[wd], dm_wdata, sel);
        end else if (g_dm && dm_l) begin
            pend      = 2;
            pend_data = ref_mem[wd];
        end
    endtask

    task automatic idle();
        logic a, b;
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, a, b);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0]   a;
        logic [AW-1:0] w;
        a = $urandom;
        if ($urandom_range(0, 3) != 0) w = AW'($urandom_range(0, 31));
        else                           w = AW'(DEPTH - 1 - $urandom_range(0, 7));
        a[AW+1:2] = w;
        return a;
    endfunction

    logic        gi, gd;
    int          im_gnts;
    logic        im_act, dm_act, dm_is_w;
    logic [31:0] im_a, dm_a, dm_d;
    logic [3:0]  dm_sel;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = 32'(i);
            ref_mem[i] = 32'(i);
        end
        model_reset();

        // Requests raised while reset is held must not be granted.
        bus.im_rd_i = 1'b1;  bus.im_addr_i = 32'h10;
        bus.dm_write_i = 1'b1; bus.dm_load_i = 1'b0; bus.dm_addr_i = 32'h20;
        bus.dm_data_s_i = 32'hFFFF_FFFF; bus.dm_data_select_i = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_im_gnt",    32'(bus.im_gnt_o),    32'h0);
        chk("rst_dm_gnt",    32'(bus.dm_gnt_o),    32'h0);
        chk("rst_ram_bwe",   32'(bus.ram_bwe_o),   32'h0);
        chk("rst_im_valid",  32'(bus.im_valid_o),  32'h0);
        chk("rst_dm_rvalid", 32'(bus.dm_rvalid_o), 32'h0);
        chk("rst_im_data",   bus.im_data_o,        32'h0);
        chk("rst_dm_data",   bus.dm_data_l_o,      32'h0);
        bus.im_rd_i = 1'b0; bus.dm_write_i = 1'b0; bus.dm_data_select_i = 4'h0;
        rst_n = 1'b1;

        // Lone fetches.
        cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, gi, gd);
        cycle(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, gi, gd);
        chk("fetch_w4", bus.im_data_o, 32'd4);
        cycle(1'b1, 32'h18, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, gi, gd);
        chk("fetch_w5", bus.im_data_o, 32'd5);
        idle();
        chk("fetch_w6", bus.im_data_o, 32'd6);

        // Contention: data first, then the held fetch.
        cycle(1'b1, 32'h20, 1'b0, 1'b1, 32'h40, 32'h0, 4'h0, gi, gd);
        chk("cont_dm_first", 32'(bus.dm_gnt_o), 32'h1);
        cycle(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, gi, gd);
        chk("cont_load", bus.dm_data_l_o, 32'd16);
        chk("cont_im_gnt", 32'(bus.im_gnt_o), 32'h1);
        idle();

        // Starvation: fetch wins every fifth cycle.
        im_gnts = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 32'h30, 1'b0, 1'b1, 32'h44, 32'h0, 4'h0, gi, gd);
            chk("starve_slot", 32'(bus.im_gnt_o), 32'((i % 5) == 4));
            im_gnts += int'(bus.im_gnt_o);
        end
        chk("starve_im_grants", 32'(im_gnts), 32'd4);
        idle();

        // Byte store then load of the same word.
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'hAABB_CCDD, 4'b0010, gi, gd);
        chk("bs_bwe", 32'(bus.ram_bwe_o), 32'h2);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h0, 4'h0, gi, gd);
        chk("bs_no_rvalid", 32'(bus.dm_rvalid_o), 32'h0);
        idle();
        chk("bs_load", bus.dm_data_l_o, 32'h0000_CC40);

        // Address wrap.
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h0001_0000, 32'h0, 4'h0, gi, gd);
        chk("wrap_addr", 32'(bus.ram_addr_o), 32'h0);
        idle();
        chk("wrap_data", bus.dm_data_l_o, 32'h0);

        // Randomised traffic: requests held until granted, occasionally dropped.
        im_act = 1'b0; dm_act = 1'b0; dm_is_w = 1'b0;
        im_a = '0; dm_a = '0; dm_d = '0; dm_sel = '0;
        for (int c = 0; c < 600; c++) begin
            if (!im_act && $urandom_range(0, 3) != 0) begin
                im_act = 1'b1;
                im_a   = rand_addr();
            end else if (im_act && $urandom_range(0, 31) == 0) begin
                im_act = 1'b0;
            end
            if (!dm_act && $urandom_range(0, 3) != 0) begin
                dm_act  = 1'b1;
                dm_is_w = 1'($urandom_range(0, 1));
                dm_a    = rand_addr();
                dm_d    = $urandom;
                dm_sel  = 4'($urandom_range(0, 15));
            end else if (dm_act && $urandom_range(0, 31) == 0) begin
                dm_act = 1'b0;
            end
            cycle(im_act, im_a, dm_act && dm_is_w, dm_act && !dm_is_w, dm_a, dm_d, dm_sel, gi, gd);
            if (gi) im_act = 1'b0;
            if (gd) dm_act = 1'b0;
        end
        idle();

        // Reset asserted right after a fetch grant discards the response.
        cycle(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, gi, gd);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.im_rd_i = 1'b0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rstmid_im_valid", 32'(bus.im_valid_o), 32'h0);
            chk("rstmid_im_data",  bus.im_data_o,       32'h0);
        end
        rst_n = 1'b1;
        idle();
        chk("rstmid_after_valid", 32'(bus.im_valid_o), 32'h0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
